sram_like_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the CPU instruction-fetch requester and the data (load/store) requester.
- Sits between the pipeline's fetch/memory stages and the SoC memory interface.
- Allows one outstanding transaction at a time, arbitrates fairly when both sides request, and discards the response of a fetch cancelled by an exception flush.

---
 rtl/arb_pkg.sv | 19 +
 rtl/sram_like_arbiter_if.sv | 53 +++++
 rtl/sram_like_arbiter.sv | 112 +++++++++++
 tb/tb_sram_like_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the SRAM-like port arbiter.
// State encoding, grant owners and access sizes.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_WAIT = 2'd1,
    DATA_WAIT = 2'd2,
    DROP_WAIT = 2'd3
  } state_e;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundle of fetch, data and memory SRAM-like buses.
// slave is the arbiter view; master is the environment.
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_cancel;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size,
    input  data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size,
    output mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size,
    output data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size,
    input  mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between fetch and data.
// One outstanding access; cancelled fetch responses are dropped.
module sram_like_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_like_arbiter_if.slave   bus
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   hold_q, hold_d;
  logic   gnt_inst, gnt_data;

  // Grant, payload mux, handshake pulses and next state.
  // Outputs are blanked during reset and the cycle after it.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    hold_d   = 1'b0;
    gnt_inst = 1'b0;
    gnt_data = 1'b0;

    bus.mem_req      = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_size     = 2'd0;
    bus.mem_addr     = {ADDR_W{1'b0}};
    bus.mem_wdata    = {DATA_W{1'b0}};
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = {DATA_W{1'b0}};
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = {DATA_W{1'b0}};

    // On a tie the side that did not win last time goes.
    gnt_data = bus.data_req &
      (!bus.inst_req || last_q == GRANT_INST);
    gnt_inst = bus.inst_req &
      (!bus.data_req || last_q == GRANT_DATA);

    if (!rst && !hold_q) begin
      unique case (state_q)
        IDLE: begin
          if (gnt_data) begin
            bus.mem_req   = 1'b1;
            bus.mem_wr    = bus.data_wr;
            bus.mem_size  = bus.data_size;
            bus.mem_addr  = bus.data_addr;
            bus.mem_wdata = bus.data_wdata;
            if (bus.mem_addr_ok) begin
              bus.data_addr_ok = 1'b1;
              last_d  = GRANT_DATA;
              state_d = DATA_WAIT;
            end
          end else if (gnt_inst) begin
            bus.mem_req  = 1'b1;
            bus.mem_size = SIZE_WORD;
            bus.mem_addr = bus.inst_addr;
            if (bus.mem_addr_ok) begin
              bus.inst_addr_ok = 1'b1;
              last_d  = GRANT_INST;
              state_d = bus.inst_cancel ?
                DROP_WAIT : INST_WAIT;
            end
          end
        end
        INST_WAIT: begin
          if (bus.mem_data_ok) begin
            state_d = IDLE;
            if (!bus.inst_cancel) begin
              bus.inst_data_ok = 1'b1;
              bus.inst_rdata   = bus.mem_rdata;
            end
          end else if (bus.inst_cancel) begin
            state_d = DROP_WAIT;
          end
        end
        DATA_WAIT: begin
          if (bus.mem_data_ok) begin
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = bus.mem_rdata;
            state_d = IDLE;
          end
        end
        DROP_WAIT: begin
          if (bus.mem_data_ok) begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // State, fairness pointer and post-reset blanking flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_INST;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for the fetch/data SRAM-like arbiter.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if bus ();

  sram_like_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = '0;
    bus.inst_cancel = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_size   = 2'd0;
    bus.data_addr   = '0;
    bus.data_wdata  = '0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_mreq"}, 64'(bus.mem_req), 64'd0);
    check({tag, "_iaok"}, 64'(bus.inst_addr_ok), 64'd0);
    check({tag, "_daok"}, 64'(bus.data_addr_ok), 64'd0);
    check({tag, "_idok"}, 64'(bus.inst_data_ok), 64'd0);
    check({tag, "_ddok"}, 64'(bus.data_data_ok), 64'd0);
    check({tag, "_maddr"}, 64'(bus.mem_addr), 64'd0);
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    rst = 1'b1;
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'hBFC0_0000;
    bus.mem_addr_ok = 1'b1;
    settle();
    outs_zero("rst");
    tick();
    rst = 1'b0;
    settle();
    outs_zero("post_rst");
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // fetch only
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'hBFC0_0000;
    bus.mem_addr_ok = 1'b1;
    settle();
    check("f_mreq", 64'(bus.mem_req), 64'd1);
    check("f_maddr", 64'(bus.mem_addr), 64'hBFC0_0000);
    check("f_mwr", 64'(bus.mem_wr), 64'd0);
    check("f_msize", 64'(bus.mem_size), 64'd2);
    check("f_iaok", 64'(bus.inst_addr_ok), 64'd1);
    check("f_daok", 64'(bus.data_addr_ok), 64'd0);
    tick();
    idle_inputs();
    settle();
    check("f_wait_mreq", 64'(bus.mem_req), 64'd0);
    check("f_wait_idok", 64'(bus.inst_data_ok), 64'd0);
    tick();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h3C1D_8000;
    settle();
    check("f_idok", 64'(bus.inst_data_ok), 64'd1);
    check("f_irdata", 64'(bus.inst_rdata), 64'h3C1D_8000);
    tick();
    bus.mem_rdata = 32'h0BAD_0BAD;
    settle();
    check("spur_idok", 64'(bus.inst_data_ok), 64'd0);
    check("spur_ddok", 64'(bus.data_data_ok), 64'd0);
    check("spur_irdata", 64'(bus.inst_rdata), 64'd0);
    check("spur_drdata", 64'(bus.data_rdata), 64'd0);

    // simultaneous requests after reset
    do_reset();
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'hBFC0_0004;
    bus.data_req    = 1'b1;
    bus.data_wr     = 1'b1;
    bus.data_size   = 2'd2;
    bus.data_addr   = 32'h8000_1000;
    bus.data_wdata  = 32'hDEAD_BEEF;
    bus.mem_addr_ok = 1'b1;
    settle();
    check("s_mwr", 64'(bus.mem_wr), 64'd1);
    check("s_mwdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    check("s_maddr", 64'(bus.mem_addr), 64'h8000_1000);
    check("s_daok", 64'(bus.data_addr_ok), 64'd1);
    check("s_iaok", 64'(bus.inst_addr_ok), 64'd0);
    tick();
    bus.data_req    = 1'b0;
    bus.mem_data_ok = 1'b1;
    settle();
    check("s_ddok", 64'(bus.data_data_ok), 64'd1);
    check("s_busy_mreq", 64'(bus.mem_req), 64'd0);
    check("s_busy_iaok", 64'(bus.inst_addr_ok), 64'd0);
    tick();
    bus.mem_data_ok = 1'b0;
    bus.data_req    = 1'b1;
    bus.data_wr     = 1'b0;
    bus.data_size   = 2'd0;
    bus.data_addr   = 32'h8000_2000;
    bus.data_wdata  = 32'h0;
    settle();
    check("s2_maddr", 64'(bus.mem_addr), 64'hBFC0_0004);
    check("s2_mwr", 64'(bus.mem_wr), 64'd0);
    check("s2_iaok", 64'(bus.inst_addr_ok), 64'd1);
    check("s2_daok", 64'(bus.data_addr_ok), 64'd0);
    tick();
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h1111_1111;
    settle();
    check("s2_idok", 64'(bus.inst_data_ok), 64'd1);
    check("s2_irdata", 64'(bus.inst_rdata), 64'h1111_1111);
    check("s2_ddok", 64'(bus.data_data_ok), 64'd0);
    tick();
    bus.mem_data_ok = 1'b0;
    bus.mem_addr_ok = 1'b1;
    settle();
    check("s3_daok", 64'(bus.data_addr_ok), 64'd1);
    check("s3_msize", 64'(bus.mem_size), 64'd0);
    check("s3_maddr", 64'(bus.mem_addr), 64'h8000_2000);
    tick();
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h0000_00AB;
    settle();
    check("s3_ddok", 64'(bus.data_data_ok), 64'd1);
    check("s3_drdata", 64'(bus.data_rdata), 64'h0000_00AB);
    tick();
    idle_inputs();

    // backpressure
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_size  = 2'd1;
    bus.data_addr  = 32'h8000_3000;
    bus.data_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp_mreq", 64'(bus.mem_req), 64'd1);
      check("bp_maddr", 64'(bus.mem_addr), 64'h8000_3000);
      check("bp_mwdata", 64'(bus.mem_wdata), 64'hCAFE_F00D);
      check("bp_msize", 64'(bus.mem_size), 64'd1);
      check("bp_daok", 64'(bus.data_addr_ok), 64'd0);
      tick();
    end
    bus.mem_addr_ok = 1'b1;
    settle();
    check("bp_daok6", 64'(bus.data_addr_ok), 64'd1);
    tick();
    idle_inputs();
    bus.mem_data_ok = 1'b1;
    settle();
    check("bp_ddok", 64'(bus.data_data_ok), 64'd1);
    tick();
    idle_inputs();

    // cancel while waiting
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'hBFC0_0010;
    bus.mem_addr_ok = 1'b1;
    settle();
    check("c_iaok", 64'(bus.inst_addr_ok), 64'd1);
    tick();
    idle_inputs();
    bus.inst_cancel = 1'b1;
    settle();
    check("c_idok0", 64'(bus.inst_data_ok), 64'd0);
    tick();
    bus.inst_cancel = 1'b0;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h1234_5678;
    settle();
    check("c_idok", 64'(bus.inst_data_ok), 64'd0);
    check("c_ddok", 64'(bus.data_data_ok), 64'd0);
    check("c_irdata", 64'(bus.inst_rdata), 64'd0);
    tick();
    idle_inputs();
    bus.data_req    = 1'b1;
    bus.data_addr   = 32'h8000_0040;
    bus.data_size   = 2'd2;
    bus.mem_addr_ok = 1'b1;
    settle();
    check("c_next_mreq", 64'(bus.mem_req), 64'd1);
    check("c_next_daok", 64'(bus.data_addr_ok), 64'd1);
    tick();
    idle_inputs();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h0000_4444;
    settle();
    check("c_next_ddok", 64'(bus.data_data_ok), 64'd1);
    check("c_next_drd", 64'(bus.data_rdata), 64'h0000_4444);
    tick();
    idle_inputs();

    // cancel coincident with response
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'hBFC0_0020;
    bus.mem_addr_ok = 1'b1;
    settle();
    check("cc_iaok", 64'(bus.inst_addr_ok), 64'd1);
    tick();
    idle_inputs();
    bus.inst_cancel = 1'b1;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h5555_5555;
    settle();
    check("cc_idok", 64'(bus.inst_data_ok), 64'd0);
    tick();
    idle_inputs();
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'hBFC0_0024;
    bus.mem_addr_ok = 1'b1;
    settle();
    check("cc_idle_iaok", 64'(bus.inst_addr_ok), 64'd1);
    check("cc_idle_maddr", 64'(bus.mem_addr), 64'hBFC0_0024);
    tick();
    idle_inputs();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h6666_6666;
    settle();
    check("cc2_idok", 64'(bus.inst_data_ok), 64'd1);
    check("cc2_irdata", 64'(bus.inst_rdata), 64'h6666_6666);
    tick();
    idle_inputs();

    // reset in DATA_WAIT
    bus.data_req    = 1'b1;
    bus.data_addr   = 32'h8000_4000;
    bus.data_size   = 2'd2;
    bus.mem_addr_ok = 1'b1;
    settle();
    check("r_daok", 64'(bus.data_addr_ok), 64'd1);
    tick();
    idle_inputs();
    rst = 1'b1;
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'hBFC0_0030;
    bus.data_req    = 1'b1;
    bus.data_addr   = 32'h8000_5000;
    bus.data_size   = 2'd2;
    bus.mem_data_ok = 1'b1;
    bus.mem_addr_ok = 1'b1;
    bus.mem_rdata   = 32'h7777_7777;
    settle();
    outs_zero("r_rst");
    check("r_rst_drd", 64'(bus.data_rdata), 64'd0);
    tick();
    rst = 1'b0;
    bus.mem_data_ok = 1'b0;
    settle();
    outs_zero("r_hold");
    tick();
    settle();
    check("r_gnt_daok", 64'(bus.data_addr_ok), 64'd1);
    check("r_gnt_iaok", 64'(bus.inst_addr_ok), 64'd0);
    check("r_gnt_maddr", 64'(bus.mem_addr), 64'h8000_5000);
    tick();
    idle_inputs();
    bus.mem_data_ok = 1'b1;
    settle();
    check("r_ddok", 64'(bus.data_data_ok), 64'd1);
    tick();
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
